// File: rtl/buff_arb_pkg.sv
// buff_arb_pkg: shared state encoding, byte type and default timing for buff_arbiter.
package buff_arb_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_START, WRITE, GAP, DRAIN} state_t;
    typedef logic [7:0] byte_t;
    localparam int DEF_READ_GAP = 5;
    localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/buff_arbiter_rr_picker.sv
// rr_picker: picks the first set request at or above ptr, wrapping modulo NREQ.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int PW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [PW-1:0]   idx,
    output logic            valid
);
    int k;
    always_comb begin
        pick = '0;
        idx = '0;
        valid = 1'b0;
        k = 0;
        // scanning downward lets the requester nearest the pointer overwrite the others
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NREQ;
            if (req[PW'(k)]) begin
                pick = '0;
                pick[PW'(k)] = 1'b1;
                idx = PW'(k);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/buff_arbiter.sv
// buff_arbiter: round-robin owner of a shared block buffer (write frame, start_read, readback).
// Defining BUFF_ARB_TIMEOUT_EN bounds the readback wait to TIMEOUT cycles after start_read.
module buff_arbiter
    import buff_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int READ_GAP = DEF_READ_GAP,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         src_start,
    input  logic [NREQ-1:0]         src_stop,
    input  logic [NREQ*8-1:0]       src_data,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic                    buf_start,
    output logic                    buf_stop,
    output byte_t                   buf_datain,
    output logic                    buf_start_read,
    input  logic                    buf_startoutput,
    input  logic                    buf_stopoutput,
    output logic                    proto_err
);
    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || READ_GAP < 1 || READ_GAP > 15 || TIMEOUT < 1) begin : g_bad_param
        $error("buff_arbiter: parameter out of range");
    end

    state_t state, state_d;
    logic [PW-1:0] rr_ptr, pick_idx;
    logic [NREQ-1:0] pick;
    logic pick_valid, fwd, o_start, o_stop, err_w, done, seen_out;
    logic [3:0] gap_cnt;
    byte_t o_data;
`ifdef BUFF_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
`endif

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req(req), .ptr(rr_ptr), .pick(pick), .idx(pick_idx), .valid(pick_valid)
    );

    assign o_start = src_start[owner];
    assign o_stop = src_stop[owner];
    assign o_data = src_data[{owner, 3'b000} +: 8];
    assign fwd = state == WAIT_START || state == WRITE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        err_w = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: state_d = pick_valid ? WAIT_START : IDLE;
            WAIT_START: state_d = o_start ? (o_stop ? GAP : WRITE) : WAIT_START;
            WRITE: begin
                err_w = o_start;
                state_d = o_stop ? GAP : WRITE;
            end
            GAP: state_d = gap_cnt == '0 ? DRAIN : GAP;
            DRAIN: begin
                if (buf_stopoutput) begin
                    done = 1'b1;
                    err_w = !(seen_out || buf_startoutput);
                end
`ifdef BUFF_ARB_TIMEOUT_EN
                if (!buf_stopoutput && tcnt == TW'(TIMEOUT - 1)) err_w = 1'b1;
                if (tcnt == TW'(TIMEOUT)) done = 1'b1;
`endif
                state_d = done ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt <= '0;
            owner <= '0;
            busy <= 1'b0;
            rr_ptr <= '0;
            buf_start <= 1'b0;
            buf_stop <= 1'b0;
            buf_datain <= '0;
            buf_start_read <= 1'b0;
            proto_err <= 1'b0;
            gap_cnt <= '0;
            seen_out <= 1'b0;
        end else begin
            buf_start <= fwd && o_start;
            buf_stop <= fwd && o_stop;
            buf_datain <= fwd ? o_data : '0;
            buf_start_read <= state == GAP && gap_cnt == '0;
            proto_err <= proto_err || err_w;
            seen_out <= state == DRAIN && (seen_out || buf_startoutput);
            // loaded one short so start_read lands READ_GAP cycles after buf_stop
            if (state_d == GAP && state != GAP) gap_cnt <= 4'(READ_GAP - 1);
            else if (state == GAP) gap_cnt <= gap_cnt - 4'd1;
            if (state == IDLE && pick_valid) begin
                gnt <= pick;
                owner <= pick_idx;
                busy <= 1'b1;
            end
            if (done) begin
                gnt <= '0;
                owner <= '0;
                busy <= 1'b0;
                rr_ptr <= owner == PW'(NREQ - 1) ? '0 : owner + PW'(1);
            end
        end
    end

`ifdef BUFF_ARB_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) tcnt <= '0;
        else tcnt <= state == DRAIN ? tcnt + TW'(1) : '0;
    end
`endif
endmodule

// File: doc/buff_arbiter.md
Name: buff_arbiter

Overview:
- Shares one block-buffer device (framed byte write, start_read pulse, framed byte readback) among NREQ requesters.
- Round-robin grants one requester at a time and forwards its start/stop/datain frame into the buffer.
- Then waits READ_GAP cycles, pulses start_read, and holds ownership until the buffer's readback frame ends (stopoutput).
- Sits between the stimulus sources and the buffer device on the bus.

Parameters:
- NREQ, 4, number of requesters (2..8).
- READ_GAP, 5, idle cycles between the forwarded stop and the start_read pulse (1..15).
- TIMEOUT, 64, maximum cycles from the start_read pulse to stopoutput (used only with BUFF_ARB_TIMEOUT_EN).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; level, held until gnt is seen.
- src_start  in  NREQ  per-requester frame start strobe.
- src_stop  in  NREQ  per-requester frame stop strobe.
- src_data  in  NREQ*8  per-requester byte; requester r occupies bits [8r+7:8r].
- gnt  out  NREQ  one-hot grant; all zero when idle.
- owner  out  $clog2(NREQ)  index of the granted requester; valid while busy.
- busy  out  1  high from grant until release.
- buf_start  out  1  start to buffer.
- buf_stop  out  1  stop to buffer.
- buf_datain  out  8  data to buffer.
- buf_start_read  out  1  one-cycle read trigger to buffer.
- buf_startoutput  in  1  buffer readback frame start.
- buf_stopoutput  in  1  buffer readback frame stop.
- proto_err  out  1  sticky; set on a protocol violation, cleared only by reset.

Behaviour:
- Reset (async, active-high): state=IDLE, rr pointer=0, and every output 0 (gnt, owner, busy, buf_start, buf_stop, buf_datain, buf_start_read, proto_err).
- IDLE:
  - Pick the first set req scanning from rr pointer upward, wrapping modulo NREQ.
  - Next cycle: gnt one-hot, owner=index, busy=1, go to WAIT_START.
  - No req: stay in IDLE.
- WAIT_START: on src_start[owner]=1, go to WRITE. No timeout in this state.
- Forwarding (WAIT_START and WRITE only):
  - buf_start, buf_stop and buf_datain are the owner's src_* values registered, giving 1-cycle latency.
  - Outside these states all three are 0.
  - Non-owner src_* inputs are ignored.
- WRITE:
  - On src_stop[owner]=1, go to GAP with counter=READ_GAP.
  - src_start[owner] while in WRITE is forwarded but sets proto_err.
  - If start and stop arrive in the same cycle (empty frame), go to GAP directly from WAIT_START.
- GAP: decrement each cycle; at 0, assert buf_start_read for exactly one cycle and go to DRAIN.
- DRAIN:
  - Wait for buf_startoutput, then buf_stopoutput.
  - Both in the same cycle counts as complete.
  - buf_stopoutput without a prior buf_startoutput sets proto_err and still completes.
  - On completion: next cycle gnt=0, busy=0, rr pointer=owner+1 mod NREQ, go to IDLE.
- Requester dropping req mid-transaction does not abort.
- Fairness: a requester holding req is granted within NREQ-1 transactions.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no partial frame is completed.

Optional Feature:
- Macro: BUFF_ARB_TIMEOUT_EN.
- Defined:
  - A counter starts at the buf_start_read pulse.
  - If buf_stopoutput is not seen within TIMEOUT cycles, set proto_err and release as on normal completion (rr advances).
- Undefined: DRAIN waits indefinitely; counter logic absent.

Decomposition:
- Package buff_arb_pkg:
  - state enum {IDLE, WAIT_START, WRITE, GAP, DRAIN}.
  - byte_t (logic [7:0]).
  - default READ_GAP and TIMEOUT constants.
- One sub-module: rr_picker (combinational; req vector + pointer -> one-hot pick and index, valid flag).

Test Plan:
- Single requester 0, 4-byte frame: buf_datain shows the 4 bytes 1 cycle after source; buf_start_read pulses exactly READ_GAP=5 cycles after buf_stop; gnt drops the cycle after buf_stopoutput.
- req=4'b1111 held, three transactions: grant order 0,1,2; then req=4'b1001 gives grant 3 before 0.
- req[2] rises while 1 owns the buffer: src_* of requester 2 never appear on buf_*; 2 is granted right after release.
- Empty frame (start=stop same cycle): go to GAP; start_read issued; no proto_err.
- buf_stopoutput with no buf_startoutput in DRAIN: proto_err=1 and stays 1 until reset; arbiter returns to IDLE.
- With BUFF_ARB_TIMEOUT_EN, TIMEOUT=64, buffer silent: proto_err at start_read+64 cycles, busy=0 next cycle; assert reset mid-WRITE: all outputs 0 asynchronously.
